// File: rtl/dpram_be_if.sv
// Port bundle for dpram_be: data port (read/write) and instruction fetch port (read-only).
// d_err exists only when DPRAM_BE_MISALIGN_ERR_EN is defined.
interface dpram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  d_req;
  logic                  d_we;
  logic [BE_W-1:0]       d_be;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ready;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_pc;
  logic                  i_ready;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_inst;
`ifdef DPRAM_BE_MISALIGN_ERR_EN
  logic                  d_err;
`endif

  modport master (
    output d_req, d_we, d_be, d_addr, d_wdata, i_req, i_pc,
    input  d_ready, d_rvalid, d_rdata, i_ready, i_rvalid, i_inst
`ifdef DPRAM_BE_MISALIGN_ERR_EN
    , input d_err
`endif
  );

  modport slave (
    input  d_req, d_we, d_be, d_addr, d_wdata, i_req, i_pc,
    output d_ready, d_rvalid, d_rdata, i_ready, i_rvalid, i_inst
`ifdef DPRAM_BE_MISALIGN_ERR_EN
    , output d_err
`endif
  );
endinterface

// File: rtl/dpram_be.sv
// Dual-port byte-enable word RAM with registered reads and post-reset zero-fill sequencer.
// Optional misaligned-access error reporting under DPRAM_BE_MISALIGN_ERR_EN.
module dpram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int INIT_ZERO  = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  dpram_be_if.slave  bus,
  output logic       init_done_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_WIDTH / 8;

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_rvalid_q, i_rvalid_d;
  logic [DATA_WIDTH-1:0] i_inst_q, i_inst_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]      d_idx, i_idx, wr_idx;
  logic                  d_acc, i_acc, d_mis;
  logic                  wr_en;
  logic [BE_W-1:0]       wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  unused_addr_bits;

  // Only the index bits (and low bits when checking alignment) matter.
  assign unused_addr_bits = ^{bus.d_addr, bus.i_pc};

  always_comb begin
    d_idx = bus.d_addr[IDX_W+1:2];
    i_idx = bus.i_pc[IDX_W+1:2];
    d_acc = bus.d_req & ready_q;
    i_acc = bus.i_req & ready_q;
`ifdef DPRAM_BE_MISALIGN_ERR_EN
    d_mis = |bus.d_addr[1:0];
`else
    d_mis = 1'b0;
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_READY;
          ready_d = 1'b1;
        end
      end
      default: ready_d = 1'b1;
    endcase

    // The zero-fill sequencer owns the write port until READY.
    if (state_q == S_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_be   = '1;
      wr_data = '0;
    end else begin
      wr_en   = d_acc & bus.d_we & ~d_mis;
      wr_idx  = d_idx;
      wr_be   = bus.d_be;
      wr_data = bus.d_wdata;
    end

    // Reads sample the array before this edge's write lands: read-first on collision.
    d_rvalid_d = d_acc & ~bus.d_we;
    d_rdata_d  = d_rdata_q;
    if (d_rvalid_d) d_rdata_d = d_mis ? '0 : mem_q[d_idx];
    i_rvalid_d = i_acc;
    i_inst_d   = i_inst_q;
    if (i_rvalid_d) i_inst_d = mem_q[i_idx];
    err_d = d_acc & d_mis;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= (INIT_ZERO != 0) ? S_INIT : S_READY;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      i_inst_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      i_inst_q   <= i_inst_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign bus.d_ready  = ready_q;
  assign bus.i_ready  = ready_q;
  assign init_done_o  = ready_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_inst   = i_inst_q;
`ifdef DPRAM_BE_MISALIGN_ERR_EN
  assign bus.d_err    = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_dpram_be.sv
// Self-checking bench for dpram_be (DEPTH = 16) against a word/byte-lane array model.
// Build with DPRAM_BE_MISALIGN_ERR_EN to cover the misalignment error variant.
module tb_dpram_be;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int BEW   = DW / 8;
`ifdef DPRAM_BE_MISALIGN_ERR_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] model [DEPTH];

  dpram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dpram_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_ZERO(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1);
  end

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit misaligned(input logic [AW-1:0] a);
    return MIS_EN && (a[1:0] != 2'b00);
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return misaligned(a) ? '0 : model[widx(a)];
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    if (!misaligned(a))
      for (int b = 0; b < BEW; b++)
        if (be[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
  endtask

  task automatic idle();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.i_req = 1'b0; bus.i_pc = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = d; bus.d_be = be;
  endtask

  // Release reset between edges and hammer both ports until ready rises; n = cycles spent.
  task automatic release_and_wait(output int n);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    drive_d(1'b1, '0, '1, '1);
    bus.i_req = 1'b1;
    while (n < 64) begin
      step();
      n++;
      if (bus.d_ready) break;
    end
    idle();
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.d_ready, bus.i_ready, init_done, bus.d_rvalid, bus.i_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b need 00000",
               {bus.d_ready, bus.i_ready, init_done, bus.d_rvalid, bus.i_rvalid});
    end
    checks++;
    if ({bus.d_rdata, bus.i_inst} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h need 0/0", bus.d_rdata, bus.i_inst);
    end
    release_and_wait(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL init_length: got %0d cycles need %0d", n, DEPTH);
    end
    checks++;
    if ({bus.d_ready, bus.i_ready, init_done} !== 3'b111) begin
      errors++;
      $display("FAIL init_ready: got %b need 111", {bus.d_ready, bus.i_ready, init_done});
    end
    model_clear();
  endtask

  task automatic test_init_zero();
    for (int k = 0; k < DEPTH; k++) begin
      bus.i_req = 1'b1;
      bus.i_pc = AW'(k * 4);
      step();
      checks++;
      if (bus.i_rvalid !== 1'b1 || bus.i_inst !== model[k] || bus.i_inst !== 32'h0) begin
        errors++;
        $display("FAIL init_zero[%0d]: got v=%b %h need v=1 %h", k, bus.i_rvalid, bus.i_inst, model[k]);
      end
    end
    idle();
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] exp;
    drive_d(1'b1, 32'h40, 32'hAABBCCDD, 4'b1111);
    model_write(32'h40, 32'hAABBCCDD, 4'b1111);
    step();
    checks++;
    if (bus.d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL be_write_rvalid: got %b need 0", bus.d_rvalid);
    end
    drive_d(1'b1, 32'h40, 32'h11223344, 4'b0101);
    model_write(32'h40, 32'h11223344, 4'b0101);
    step();
    drive_d(1'b0, 32'h40, '0, '0);
    exp = model_read(32'h40);
    step();
    idle();
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== exp || bus.d_rdata !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL be_read: got v=%b %h need v=1 %h", bus.d_rvalid, bus.d_rdata, 32'hAA22CC44);
    end
    step();
    checks++;
    if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== exp) begin
      errors++;
      $display("FAIL idle_hold: got v=%b %h need v=0 %h", bus.d_rvalid, bus.d_rdata, exp);
    end
    drive_d(1'b1, 32'h40, 32'h0, 4'b0000);
    step();
    drive_d(1'b0, 32'h40, '0, '0);
    step();
    idle();
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== model_read(32'h40)) begin
      errors++;
      $display("FAIL be_zero: got v=%b %h need v=1 %h", bus.d_rvalid, bus.d_rdata, model_read(32'h40));
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] old;
    old = model[widx(32'h8)];
    drive_d(1'b1, 32'h8, 32'hDEADBEEF, 4'b1111);
    bus.i_req = 1'b1; bus.i_pc = 32'h8;
    model_write(32'h8, 32'hDEADBEEF, 4'b1111);
    step();
    bus.d_req = 1'b0;
    checks++;
    if (bus.i_rvalid !== 1'b1 || bus.i_inst !== old) begin
      errors++;
      $display("FAIL collision_old: got v=%b %h need v=1 %h", bus.i_rvalid, bus.i_inst, old);
    end
    step();
    idle();
    checks++;
    if (bus.i_rvalid !== 1'b1 || bus.i_inst !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL collision_new: got v=%b %h need v=1 %h", bus.i_rvalid, bus.i_inst, 32'hDEADBEEF);
    end
  endtask

  task automatic test_alias();
    logic [DW-1:0] exp;
    drive_d(1'b1, 32'h3, 32'h5, 4'b1111);
    model_write(32'h3, 32'h5, 4'b1111);
    step();
`ifdef DPRAM_BE_MISALIGN_ERR_EN
    checks++;
    if (bus.d_err !== 1'b1) begin
      errors++;
      $display("FAIL err_on_write: got %b need 1", bus.d_err);
    end
`endif
    drive_d(1'b0, 32'h43, '0, '0);
    exp = model_read(32'h43);
    step();
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== exp) begin
      errors++;
      $display("FAIL alias_read: got v=%b %h need v=1 %h", bus.d_rvalid, bus.d_rdata, exp);
    end
    drive_d(1'b0, 32'h40, '0, '0);
    exp = model_read(32'h40);
    step();
    idle();
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== exp) begin
      errors++;
      $display("FAIL alias_aligned: got v=%b %h need v=1 %h", bus.d_rvalid, bus.d_rdata, exp);
    end
`ifdef DPRAM_BE_MISALIGN_ERR_EN
    checks++;
    if (bus.d_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b need 0", bus.d_err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w;
    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      drive_d(1'b1, AW'(k * 4), w, 4'b1111);
      model_write(AW'(k * 4), w, 4'b1111);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      drive_d(1'b0, AW'(k * 4), '0, '0);
      bus.i_req = 1'b1;
      bus.i_pc = AW'((7 - k) * 4) | (AW'($urandom_range(0, 15)) << 6);
      step();
      checks++;
      if (bus.d_rvalid !== 1'b1 || bus.i_rvalid !== 1'b1 ||
          bus.d_rdata !== model[k] || bus.i_inst !== model[7 - k]) begin
        errors++;
        $display("FAIL b2b[%0d]: got %b%b %h %h need 11 %h %h", k, bus.d_rvalid, bus.i_rvalid,
                 bus.d_rdata, bus.i_inst, model[k], model[7 - k]);
      end
    end
    idle();
    step();
    checks++;
    if ({bus.d_rvalid, bus.i_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_drain: got %b need 00", {bus.d_rvalid, bus.i_rvalid});
    end
  endtask

  task automatic test_random();
    logic          dreq, dwe, ireq, exp_dv, exp_iv, exp_err;
    logic [AW-1:0] a, pc;
    logic [DW-1:0] wd, exp_dd, exp_ii;
    logic [BEW-1:0] be;
    exp_dd = '0; exp_ii = '0;
    for (int c = 0; c < 300; c++) begin
      dreq = (c == 0) || ($urandom_range(0, 3) != 0);
      dwe  = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ireq = (c == 0) || ($urandom_range(0, 3) != 0);
      a    = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      pc   = $urandom;
      wd   = $urandom;
      be   = BEW'($urandom);
      bus.d_req = dreq; bus.d_we = dwe; bus.d_addr = a; bus.d_wdata = wd; bus.d_be = be;
      bus.i_req = ireq; bus.i_pc = pc;
      exp_dv  = dreq && !dwe;
      if (exp_dv) exp_dd = model_read(a);
      exp_iv  = ireq;
      if (exp_iv) exp_ii = model[widx(pc)];
      exp_err = dreq && misaligned(a);
      if (dreq && dwe) model_write(a, wd, be);
      step();
      checks++;
      if (bus.d_rvalid !== exp_dv || bus.d_rdata !== exp_dd ||
          bus.i_rvalid !== exp_iv || bus.i_inst !== exp_ii) begin
        errors++;
        $display("FAIL random[%0d]: got %b %h %b %h need %b %h %b %h", c, bus.d_rvalid, bus.d_rdata,
                 bus.i_rvalid, bus.i_inst, exp_dv, exp_dd, exp_iv, exp_ii);
      end
`ifdef DPRAM_BE_MISALIGN_ERR_EN
      checks++;
      if (bus.d_err !== exp_err) begin
        errors++;
        $display("FAIL random_err[%0d]: got %b need %b", c, bus.d_err, exp_err);
      end
`else
      if (exp_err) errors += 0;
`endif
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n;
    drive_d(1'b0, 32'h8, '0, '0);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.d_ready, init_done, bus.d_rvalid, bus.i_rvalid} !== 4'b0 || bus.d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_read: got %b %h need 0000 0",
               {bus.d_ready, init_done, bus.d_rvalid, bus.i_rvalid}, bus.d_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) step();
    checks++;
    if ({bus.d_ready, bus.i_ready, init_done} !== 3'b000) begin
      errors++;
      $display("FAIL mid_init_ready: got %b need 000", {bus.d_ready, bus.i_ready, init_done});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.d_ready, bus.i_ready, init_done, bus.d_rvalid, bus.i_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_init: got %b need 00000",
               {bus.d_ready, bus.i_ready, init_done, bus.d_rvalid, bus.i_rvalid});
    end
    release_and_wait(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL reinit_length: got %0d cycles need %0d", n, DEPTH);
    end
    model_clear();
    test_init_zero();
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_byte_enable();
    test_collision();
    test_alias();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram_be.md
Name: dpram_be

Overview:
- Parametrised dual-port word RAM. Successor to the existing combinational-read unified instruction/data memory.
- Adds registered reads (1-cycle latency) on both ports, per-byte write enables and valid handshakes.
- Adds a post-reset zero-initialisation sequencer.
- Sits between the core's LSU/fetch stages and local memory; the data port reads/writes, the instruction port is read-only.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width on both ports.
- DEPTH, 1024, number of words; power of two, minimum 2.
- INIT_ZERO, 1, 1 = clear all words after reset before accepting requests; 0 = ready immediately, contents undefined.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- d_req_i  in  1  data-port request.
- d_we_i  in  1  1 = write, 0 = read.
- d_be_i  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- d_addr_i  in  ADDR_WIDTH  byte address.
- d_wdata_i  in  DATA_WIDTH  write data.
- d_ready_o  out  1  port accepting requests.
- d_rvalid_o  out  1  read data valid.
- d_rdata_o  out  DATA_WIDTH  read data.
- i_req_i  in  1  fetch request.
- i_pc_i  in  ADDR_WIDTH  fetch byte address.
- i_ready_o  out  1  port accepting requests.
- i_rvalid_o  out  1  instruction valid.
- i_inst_o  out  DATA_WIDTH  instruction word.
- init_done_o  out  1  initialisation complete.

Behaviour:
- Reset (rst_ni = 0, asynchronous): all outputs are 0; FSM enters INIT if INIT_ZERO = 1, else READY; init counter = 0. Memory contents are not reset.
- Word index is addr[$clog2(DEPTH)+1:2]. Low two address bits are ignored (alignment is forced). Upper address bits alias, so indices wrap modulo DEPTH.
- FSM INIT:
  - d_ready_o = i_ready_o = 0.
  - One word is written to 0 per cycle at the counter index; the counter increments.
  - When the counter reaches DEPTH-1, that word is written and the FSM moves to READY on the next edge. INIT takes exactly DEPTH cycles.
  - Requests during INIT are ignored, with no side effects.
- FSM READY:
  - d_ready_o = i_ready_o = init_done_o = 1. READY has no exit except reset.
- Handshake: a request is accepted on a rising edge where req & ready.
- Write accept: at that edge, only lanes with be[i] = 1 are updated; d_rvalid_o stays 0.
- Read accept: the word is captured at that edge. rvalid = 1 and rdata is valid in the following cycle, so latency = 1. Back-to-back reads sustain 1 per cycle.
- No request accepted: rvalid = 0 in the next cycle. rdata holds its last value; it is not zeroed.
- Write with d_be_i = 0: no memory change, still accepted.
- Same-cycle data write and fetch to the same index: the fetch returns the OLD word (read-first). The following fetch sees the new data.
- Data read and data write cannot coincide; the data port carries one operation per cycle.
- Reset mid-INIT or mid-read: rvalid drops immediately and the pending read is discarded. INIT restarts from index 0.
- Both ports are fully independent; neither ever stalls the other once in READY.

Optional Feature:
- Macro: DPRAM_BE_MISALIGN_ERR_EN.
- With the macro defined, extra output d_err_o (1 bit, reset 0).
  - An accepted data request with d_addr_i[1:0] != 0 sets d_err_o = 1 for exactly the following cycle.
  - A misaligned write is suppressed: memory is unchanged.
  - A misaligned read still returns rvalid = 1, with rdata = 0.
  - Fetch misalignment is not checked.
- Without the macro: no d_err_o port; low address bits are silently ignored as above.

Test Plan:
1. Init sequence: DEPTH = 16, INIT_ZERO = 1, release reset -> ready/init_done low for exactly 16 cycles, then high; fetch of every index returns 0x00000000.
2. Byte-enable write: write 0xAABBCCDD with be = 4'b1111 at 0x40, then 0x11223344 with be = 4'b0101 at 0x40; read 0x40 -> rvalid one cycle after accept, rdata = 0xAA22CC44.
3. Collision: same cycle, data write 0xDEADBEEF at 0x8 and fetch 0x8 (old value 0) -> i_inst_o = 0x00000000; next fetch of 0x8 -> 0xDEADBEEF.
4. Aliasing/alignment: DEPTH = 16, write 0x5 at address 0x3, read 0x43 -> 0x00000005 (index wraps, low bits ignored); with the macro on -> write suppressed, d_err_o pulses, rdata = 0.
5. Reset mid-INIT: assert rst_ni at init cycle 7 -> outputs zero immediately; after release, a full DEPTH-cycle INIT restarts.
6. Throughput: 8 back-to-back data reads plus concurrent fetches -> rvalid high on both ports for 8 consecutive cycles, each word correct.
